// File: rtl/button_pkg.sv
// -----------------------------------------------------------------------------
// button_pkg
// Shared definitions for the button event decoder:
//   - FSM state encodings (2-bit, legacy-compatible localparams)
//   - default timing constants
//   - saturating 8-bit increment used by the press counter
// -----------------------------------------------------------------------------
package button_pkg;

   localparam logic [1:0] ST_IDLE      = 2'b00;
   localparam logic [1:0] ST_PRESSED   = 2'b01;
   localparam logic [1:0] ST_REPEATING = 2'b10;

   localparam int TICK_BITS_DEF    = 19;
   localparam int LONG_TICKS_DEF   = 100;
   localparam int REPEAT_TICKS_DEF = 20;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
// Free-running TICK_BITS-wide counter. o_tick is high while the count is all
// ones, i.e. once every 2^TICK_BITS cycles. i_clr restarts the count at zero,
// so the first tick after a clear lands exactly 2^TICK_BITS cycles later.
//
// Ports:
//   i_clk    system clock, rising edge
//   i_reset  asynchronous reset, active low
//   i_clr    synchronous clear of the count
//   o_tick   one cycle in every 2^TICK_BITS cycles
// -----------------------------------------------------------------------------
module tick_prescaler
   import button_pkg::*;
#(
   parameter int TICK_BITS = TICK_BITS_DEF
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_clr,
   output logic o_tick
);

   logic [TICK_BITS-1:0] r_count;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + TICK_BITS'(1);
      end
   end

   assign o_tick = &r_count;

endmodule

// File: rtl/button_event_decoder.sv
// -----------------------------------------------------------------------------
// button_event_decoder
// Turns the debounced button level into single-cycle events: press, release,
// long_press (hold reached LONG_TICKS) and auto-repeat (every REPEAT_TICKS
// after long_press). All event outputs are registered; at most one is high.
//
// Ports:
//   i_clk           system clock, rising edge
//   i_reset         asynchronous reset, active low
//   i_db            debounced button level
//   o_press         one-cycle pulse on press
//   o_release       one-cycle pulse on release
//   o_long_press    one-cycle pulse when the hold reaches LONG_TICKS
//   o_repeat        one-cycle pulse every REPEAT_TICKS after long_press
//   o_held          1 while PRESSED or REPEATING
//   o_press_count   saturating count of press events
//
// LONG_TICKS must be 2..255 and REPEAT_TICKS 1..255 (8-bit hold counter).
// -----------------------------------------------------------------------------
module button_event_decoder
   import button_pkg::*;
#(
   parameter int TICK_BITS    = TICK_BITS_DEF,
   parameter int LONG_TICKS   = LONG_TICKS_DEF,
   parameter int REPEAT_TICKS = REPEAT_TICKS_DEF
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_db,
   output logic       o_press,
   output logic       o_release,
   output logic       o_long_press,
   output logic       o_repeat,
   output logic       o_held,
   output logic [7:0] o_press_count
);

   localparam logic [7:0] LONG_LAST   = 8'(LONG_TICKS - 1);
   localparam logic [7:0] REPEAT_LAST = 8'(REPEAT_TICKS - 1);

   logic       r_db_q;
   logic       r_db_qq;
   logic       r_q_valid;
   logic       r_seen_low;
   logic [1:0] r_state;
   logic [7:0] r_hold;
   logic [7:0] r_count;
   logic       r_press;
   logic       r_release;
   logic       r_long;
   logic       r_repeat;
   logic       r_held;

   logic       w_tick;
   logic       w_clr;
   logic       w_rise;
   logic [1:0] w_state_next;
   logic [7:0] w_hold_next;
   logic [7:0] w_count_next;
   logic       w_press_next;
   logic       w_release_next;
   logic       w_long_next;
   logic       w_repeat_next;

   tick_prescaler #(
      .TICK_BITS (TICK_BITS)
   ) u_prescaler (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_clr   (w_clr),
      .o_tick  (w_tick)
   );

   // A rising edge only counts once db_q has held a real low sample since
   // reset; a button already down when reset ends must be let go first.
   assign w_rise = r_db_q & ~r_db_qq & r_seen_low;

   always_comb begin
      w_state_next   = r_state;
      w_hold_next    = r_hold;
      w_count_next   = r_count;
      w_press_next   = 1'b0;
      w_release_next = 1'b0;
      w_long_next    = 1'b0;
      w_repeat_next  = 1'b0;
      w_clr          = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_rise) begin
               w_state_next = ST_PRESSED;
               w_press_next = 1'b1;
               w_clr        = 1'b1;
               w_hold_next  = '0;
               w_count_next = sat_inc8(r_count);
            end
         end
         ST_PRESSED: begin
            // Release is checked first so it beats a coincident threshold tick.
            if (!r_db_q) begin
               w_state_next   = ST_IDLE;
               w_release_next = 1'b1;
            end else if (w_tick) begin
               if (r_hold == LONG_LAST) begin
                  w_state_next = ST_REPEATING;
                  w_long_next  = 1'b1;
                  w_hold_next  = '0;
               end else begin
                  w_hold_next = r_hold + 8'd1;
               end
            end
         end
         ST_REPEATING: begin
            if (!r_db_q) begin
               w_state_next   = ST_IDLE;
               w_release_next = 1'b1;
            end else if (w_tick) begin
               if (r_hold == REPEAT_LAST) begin
                  w_repeat_next = 1'b1;
                  w_hold_next   = '0;
               end else begin
                  w_hold_next = r_hold + 8'd1;
               end
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_db_q     <= 1'b0;
         r_db_qq    <= 1'b0;
         r_q_valid  <= 1'b0;
         r_seen_low <= 1'b0;
         r_state    <= ST_IDLE;
         r_hold     <= '0;
         r_count    <= '0;
         r_press    <= 1'b0;
         r_release  <= 1'b0;
         r_long     <= 1'b0;
         r_repeat   <= 1'b0;
         r_held     <= 1'b0;
      end else begin
         r_db_q     <= i_db;
         r_db_qq    <= r_db_q;
         r_q_valid  <= 1'b1;
         r_seen_low <= r_seen_low | (r_q_valid & ~r_db_q);
         r_state    <= w_state_next;
         r_hold     <= w_hold_next;
         r_count    <= w_count_next;
         r_press    <= w_press_next;
         r_release  <= w_release_next;
         r_long     <= w_long_next;
         r_repeat   <= w_repeat_next;
         r_held     <= (w_state_next == ST_PRESSED) || (w_state_next == ST_REPEATING);
      end
   end

   assign o_press       = r_press;
   assign o_release     = r_release;
   assign o_long_press  = r_long;
   assign o_repeat      = r_repeat;
   assign o_held        = r_held;
   assign o_press_count = r_count;

endmodule

// File: doc/button_event_decoder.md
Name: button_event_decoder

Overview:
- Consumes the debounced level `db` produced by the switch debouncer stage and turns it into single-cycle button events:
  - press
  - release
  - long-press
  - auto-repeat
- Sits between the debouncer and the control FSMs that act on user buttons.
- Runs on the same clock and owns its own timing prescaler, so event timing is deterministic relative to the press.

Parameters:
- TICK_BITS, 19, prescaler width; one tick = 2^TICK_BITS clk cycles (10.49 ms at 50 MHz).
- LONG_TICKS, 100, ticks of continuous hold before long_press fires (range 2..255).
- REPEAT_TICKS, 20, ticks between repeat pulses after long_press (range 1..255).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- db  input  1  debounced button level from the debouncer.
- press  output  1  one-cycle pulse on press.
- release  output  1  one-cycle pulse on release.
- long_press  output  1  one-cycle pulse when the hold reaches LONG_TICKS.
- repeat  output  1  one-cycle pulse every REPEAT_TICKS while held after long_press.
- held  output  1  registered level, 1 while in PRESSED or REPEATING.
- press_count  output  8  saturating count of press events.

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs are 0, press_count=0, state=IDLE.
  - Prescaler=0, hold counter=0, db_q=0.
  - Reset mid-hold generates no release pulse.
- Input stage: db is registered once into db_q. db is a combinational decode upstream and must not feed the FSM directly.
- Rise/fall of db_q is detected against its previous value db_qq.
- State machine (registered, 2-bit encoding):
  - IDLE: on db_q=1 && db_qq=0 -> PRESSED. Assert press for one cycle, clear prescaler and hold counter, increment press_count (saturates at 255).
  - PRESSED:
    - On db_q=0 -> IDLE, assert release.
    - Else on tick: if hold==LONG_TICKS-1 -> REPEATING, assert long_press, clear hold. Otherwise hold++.
  - REPEATING:
    - On db_q=0 -> IDLE, assert release.
    - Else on tick: if hold==REPEAT_TICKS-1 -> assert repeat, clear hold. Otherwise hold++.
  - Unused encoding -> IDLE, no pulses.
- Prescaler: free-running TICK_BITS counter. tick=1 when the count is all ones. It is cleared synchronously in the press cycle, so the first tick occurs exactly 2^TICK_BITS cycles after press.
- Latency:
  - db rising at edge k -> db_q at k -> press is high for the cycle following edge k+1 (2-edge latency).
  - Release has the same latency.
- Timing relative to the press pulse:
  - long_press asserts exactly LONG_TICKS*2^TICK_BITS cycles after press.
  - Each repeat follows the previous long_press/repeat by REPEAT_TICKS*2^TICK_BITS cycles.
- All event outputs are registered. At most one of press/release/long_press/repeat is high in any cycle.
- Simultaneous events: release and a threshold tick in the same cycle -> release wins; long_press/repeat are suppressed.
- held: 1 from the press cycle through the cycle before the release pulse; 0 in the release cycle.
- db stuck high out of reset produces no press (a rising edge is required).

Decomposition:
- Shared package (button_pkg) holds:
  - state encodings: IDLE=2'b00, PRESSED=2'b01, REPEATING=2'b10
  - default constants TICK_BITS_DEF=19, LONG_TICKS_DEF=100, REPEAT_TICKS_DEF=20
- One sub-module, tick_prescaler:
  - Parameter: TICK_BITS.
  - Ports: clk, reset, clr, tick.
  - Instantiated once.
- Hold counter and FSM live in the top module.

Test Plan:
(bench uses TICK_BITS=4, LONG_TICKS=3, REPEAT_TICKS=2)
- Short press: db high for 20 cycles then low.
  - press at cycle 2 after the rise; release at cycle 2 after the fall.
  - No long_press; press_count=1; held high for 20 cycles.
- Long hold: db high for 150 cycles.
  - long_press exactly 48 cycles after press.
  - repeat every 32 cycles thereafter (cycles 80, 112, 144 after press).
  - Single release after the fall.
- Release collision: db falls so that db_q=0 coincides with the 48th-cycle tick.
  - release asserted, long_press never asserted, state returns to IDLE.
- Reset mid-hold: reset=0 at cycle 30 of a hold.
  - All outputs go 0 immediately (asynchronous), no release pulse.
  - With db still high after reset deasserts, no press until db falls and rises again.
- Saturation: 260 short presses -> press_count stops at 255; press pulses continue for every press.
- One-hot events: random db toggling (min 2-cycle pulses), 10k cycles -> at most one event output high per cycle; press and release counts differ by at most 1.
